// File: rtl/gol_pixel_streamer.sv
// gol_pixel_streamer
//   Streams one Game-of-Life grid frame as 24-bit RGB pixels, row-major, one
//   pixel per AXI-Stream-style handshake. The grid lives in an external memory
//   that returns one WIDTH-bit row one cycle after a read strobe. The next row
//   is prefetched into a shadow register while the current row streams, so
//   there is no valid bubble between rows.
//
//   Ports
//     clk, reset        rising-edge clock, asynchronous active-high reset
//     start             one-cycle frame request (honoured only in IDLE)
//     busy              high while a frame is in flight (low in DONE)
//     rd_row_en/addr    row read strobe and row index
//     rd_row_data       row word, bit c = column c, valid one cycle after strobe
//     pix_tdata/tvalid/tready/tuser/tlast
//                       pixel stream; tuser marks (0,0), tlast marks col WIDTH-1
//     frame_done        one-cycle pulse after the last pixel transfers
//
//   WIDTH and HEIGHT must both be at least 2: with a single column the row
//   would end before its prefetched successor could arrive.

module gol_pixel_streamer #(
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter logic [23:0] ALIVE_RGB = 24'hFFFFFF,
  parameter logic [23:0] DEAD_RGB  = 24'h000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      rd_row_en,
  output logic [$clog2(HEIGHT)-1:0] rd_row_addr,
  input  logic [WIDTH-1:0]          rd_row_data,
  output logic [23:0]               pix_tdata,
  output logic                      pix_tvalid,
  input  logic                      pix_tready,
  output logic                      pix_tuser,
  output logic                      pix_tlast,
  output logic                      frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, STREAM, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] active_row;
  logic [WIDTH-1:0] shadow_row;
  logic             shadow_load;   // rd_row_data currently carries the prefetched row

  logic             handshake;
  logic             at_row_end;
  logic             at_frame_end;
  logic [CW-1:0]    col_next;
  logic [WIDTH-1:0] next_row_bits;

  assign handshake    = pix_tvalid && pix_tready;
  assign at_row_end   = (col == COL_LAST);
  assign at_frame_end = at_row_end && (row == ROW_LAST);
  assign col_next     = col + CW'(1);
  // For short rows the prefetched word may still be on the bus when the row
  // ends; take it straight from the bus rather than from the stale shadow.
  assign next_row_bits = shadow_load ? rd_row_data : shadow_row;

  function automatic logic [23:0] pixel_of(input logic alive);
    return alive ? ALIVE_RGB : DEAD_RGB;
  endfunction

  // NOTE: the row registers are plain data storage and carry no reset; the
  // registered pix_tdata resets to DEAD_RGB and is only ever loaded from them
  // after a CAPTURE, so their power-up contents can never reach the output.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      active_row <= rd_row_data;
    end else if (state == STREAM && handshake && at_row_end && !at_frame_end) begin
      active_row <= next_row_bits;
    end
    if (shadow_load) begin
      shadow_row <= rd_row_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      busy        <= 1'b0;
      rd_row_en   <= 1'b0;
      rd_row_addr <= '0;
      shadow_load <= 1'b0;
      pix_tvalid  <= 1'b0;
      pix_tdata   <= DEAD_RGB;
      pix_tuser   <= 1'b0;
      pix_tlast   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      rd_row_en   <= 1'b0;
      frame_done  <= 1'b0;
      // Only a strobe issued while streaming is a prefetch for the shadow.
      shadow_load <= rd_row_en && (state == STREAM);

      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            rd_row_en   <= 1'b1;
            rd_row_addr <= '0;
            col         <= '0;
            row         <= '0;
          end
        end

        FETCH: state <= CAPTURE;

        CAPTURE: begin
          // Row 0 arrives now; present its first pixel and prefetch row 1.
          state       <= STREAM;
          pix_tvalid  <= 1'b1;
          pix_tdata   <= pixel_of(rd_row_data[0]);
          pix_tuser   <= 1'b1;
          pix_tlast   <= 1'b0;
          rd_row_en   <= 1'b1;
          rd_row_addr <= RW'(1);
        end

        STREAM: begin
          if (handshake) begin
            pix_tuser <= 1'b0;
            if (at_frame_end) begin
              state      <= DONE;
              pix_tvalid <= 1'b0;
              pix_tdata  <= DEAD_RGB;
              pix_tlast  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              col        <= '0;
              row        <= '0;
            end else if (at_row_end) begin
              col       <= '0;
              row       <= row + RW'(1);
              pix_tdata <= pixel_of(next_row_bits[0]);
              pix_tlast <= 1'b0;
              // The row now starting is not the last one: fetch its successor.
              if (row + RW'(1) != ROW_LAST) begin
                rd_row_en   <= 1'b1;
                rd_row_addr <= row + RW'(2);
              end
            end else begin
              col       <= col_next;
              pix_tdata <= pixel_of(active_row[col_next]);
              pix_tlast <= (col_next == COL_LAST);
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
